// File: rtl/chord_game_if.sv
// Player-side handshake bundle for chord_game_ctrl: debounced inputs in, renderer/status outputs out.
// The hint pulse exists only when CHORD_HINT_EN is defined.
interface chord_game_if;
  logic        start;
  logic [11:0] key_toggle;
  logic        submit;
`ifdef CHORD_HINT_EN
  logic        hint;
`endif
  logic [11:0] key_select;
  logic [2:0]  level;
  logic [3:0]  score;
  logic [1:0]  misses;
  logic [2:0]  state_o;
  logic        game_over;
  logic        win;

`ifdef CHORD_HINT_EN
  modport master (
    output start, key_toggle, submit, hint,
    input  key_select, level, score, misses, state_o, game_over, win
  );
  modport slave (
    input  start, key_toggle, submit, hint,
    output key_select, level, score, misses, state_o, game_over, win
  );
`else
  modport master (
    output start, key_toggle, submit,
    input  key_select, level, score, misses, state_o, game_over, win
  );
  modport slave (
    input  start, key_toggle, submit,
    output key_select, level, score, misses, state_o, game_over, win
  );
`endif
endinterface

// File: rtl/chord_game_ctrl.sv
// Chord game sequencer: shows a target chord, collects key toggles, scores submissions.
// Optional macro CHORD_HINT_EN adds a hint pulse that replays the target without losing the selection.
module chord_game_ctrl #(
  parameter int unsigned SHOW_CYCLES = 50_000_000,
  parameter int unsigned FB_CYCLES   = 25_000_000,
  parameter int unsigned NUM_CHORDS  = 8,
  parameter int unsigned MAX_MISSES  = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  chord_game_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHOW      = 3'd1,
    ST_PLAY      = 3'd2,
    ST_CHECK     = 3'd3,
    ST_CORRECT   = 3'd4,
    ST_WRONG     = 3'd5,
    ST_GAME_OVER = 3'd6,
    ST_WIN       = 3'd7
  } state_e;

  localparam logic [26:0] SHOW_LAST  = 27'(SHOW_CYCLES - 1);
  localparam logic [26:0] FB_LAST    = 27'(FB_CYCLES - 1);
  localparam logic [2:0]  LAST_LEVEL = 3'(NUM_CHORDS - 1);
  localparam logic [1:0]  MISS_LIMIT = 2'(MAX_MISSES);

  function automatic logic [11:0] chord_of(input logic [2:0] idx);
    case (idx)
      3'd0:    chord_of = 12'h091;
      3'd1:    chord_of = 12'h221;
      3'd2:    chord_of = 12'h884;
      3'd3:    chord_of = 12'h224;
      3'd4:    chord_of = 12'h211;
      3'd5:    chord_of = 12'h890;
      3'd6:    chord_of = 12'h244;
      default: chord_of = 12'h910;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [26:0] timer_q, timer_d;
  logic [11:0] sel_q, sel_d;
  logic [2:0]  level_q, level_d;
  logic [3:0]  score_q, score_d;
  logic [1:0]  misses_q, misses_d;
  logic [11:0] key_select_q, key_select_d;
  logic        game_over_q, game_over_d;
  logic        win_q, win_d;
  logic [11:0] target;
`ifdef CHORD_HINT_EN
  logic        hint_used_q, hint_used_d;
  logic        hint_return_q, hint_return_d;
`endif

  assign target = chord_of(level_q);

  always_comb begin
    // NOTE: every _d takes its _q value first so no path through this block can infer a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    sel_d     = sel_q;
    level_d   = level_q;
    score_d   = score_q;
    misses_d  = misses_q;
`ifdef CHORD_HINT_EN
    hint_used_d   = hint_used_q;
    hint_return_d = hint_return_q;
`endif

    case (state_q)
      ST_IDLE, ST_GAME_OVER, ST_WIN: begin
        if (bus.start) begin
          state_d  = ST_SHOW;
          timer_d  = '0;
          sel_d    = '0;
          level_d  = '0;
          score_d  = '0;
          misses_d = '0;
`ifdef CHORD_HINT_EN
          hint_used_d   = 1'b0;
          hint_return_d = 1'b0;
`endif
        end
      end
      ST_SHOW: begin
        if (timer_q == SHOW_LAST) begin
          state_d = ST_PLAY;
          timer_d = '0;
`ifdef CHORD_HINT_EN
          // A hint replay returns to the selection the player already had.
          if (!hint_return_q) sel_d = '0;
          hint_return_d = 1'b0;
`else
          sel_d = '0;
`endif
        end else begin
          timer_d = timer_q + 27'd1;
        end
      end
      ST_PLAY: begin
        sel_d = sel_q ^ bus.key_toggle;
        if (bus.submit) begin
          state_d = ST_CHECK;
        end
`ifdef CHORD_HINT_EN
        else if (bus.hint) begin
          state_d       = ST_SHOW;
          timer_d       = '0;
          hint_used_d   = 1'b1;
          hint_return_d = 1'b1;
        end
`endif
      end
      ST_CHECK: begin
        timer_d = '0;
        if (sel_q == target) begin
          state_d = ST_CORRECT;
`ifdef CHORD_HINT_EN
          if (score_q != 4'hF && !hint_used_q) score_d = score_q + 4'd1;
`else
          if (score_q != 4'hF) score_d = score_q + 4'd1;
`endif
        end else begin
          state_d = ST_WRONG;
          if (misses_q != MISS_LIMIT) misses_d = misses_q + 2'd1;
        end
      end
      ST_CORRECT: begin
        if (timer_q == FB_LAST) begin
          timer_d = '0;
          if (level_q >= LAST_LEVEL) begin
            state_d = ST_WIN;
          end else begin
            state_d = ST_SHOW;
            level_d = level_q + 3'd1;
`ifdef CHORD_HINT_EN
            hint_used_d = 1'b0;
`endif
          end
        end else begin
          timer_d = timer_q + 27'd1;
        end
      end
      ST_WRONG: begin
        if (timer_q == FB_LAST) begin
          timer_d = '0;
          state_d = (misses_q == MISS_LIMIT) ? ST_GAME_OVER : ST_SHOW;
        end else begin
          timer_d = timer_q + 27'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register together with it.
    case (state_d)
      ST_SHOW, ST_CORRECT: key_select_d = chord_of(level_d);
      ST_PLAY, ST_CHECK:   key_select_d = sel_d;
      ST_WRONG:            key_select_d = sel_d ^ chord_of(level_d);
      ST_WIN:              key_select_d = 12'hFFF;
      default:             key_select_d = 12'h000;
    endcase
    game_over_d = (state_d == ST_GAME_OVER);
    win_d       = (state_d == ST_WIN);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      sel_q        <= '0;
      level_q      <= '0;
      score_q      <= '0;
      misses_q     <= '0;
      key_select_q <= '0;
      game_over_q  <= 1'b0;
      win_q        <= 1'b0;
`ifdef CHORD_HINT_EN
      hint_used_q   <= 1'b0;
      hint_return_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      sel_q        <= sel_d;
      level_q      <= level_d;
      score_q      <= score_d;
      misses_q     <= misses_d;
      key_select_q <= key_select_d;
      game_over_q  <= game_over_d;
      win_q        <= win_d;
`ifdef CHORD_HINT_EN
      hint_used_q   <= hint_used_d;
      hint_return_q <= hint_return_d;
`endif
    end
  end

  assign bus.key_select = key_select_q;
  assign bus.level      = level_q;
  assign bus.score      = score_q;
  assign bus.misses     = misses_q;
  assign bus.state_o    = state_q;
  assign bus.game_over  = game_over_q;
  assign bus.win        = win_q;

endmodule

// File: tb/tb_chord_game_ctrl.sv
// Bench for chord_game_ctrl: two instances (8-chord and 2-chord games) share one stimulus stream
// and are compared every cycle against a countdown-based game model.
module tb_chord_game_ctrl;

  localparam int SHOW = 4;
  localparam int FB   = 2;
  localparam int MAXM = 3;
  localparam bit [11:0] CHORDS [8] = '{12'h091, 12'h221, 12'h884, 12'h224,
                                       12'h211, 12'h890, 12'h244, 12'h910};

  typedef struct {
    int        st;
    int        left;
    bit [11:0] sel;
    int        level;
    int        score;
    int        misses;
  } mdl_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  mdl_t m8;
  mdl_t m2;

  chord_game_if if8 ();
  chord_game_if if2 ();

  chord_game_ctrl #(.SHOW_CYCLES(SHOW), .FB_CYCLES(FB), .NUM_CHORDS(8), .MAX_MISSES(MAXM))
    dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  chord_game_ctrl #(.SHOW_CYCLES(SHOW), .FB_CYCLES(FB), .NUM_CHORDS(2), .MAX_MISSES(MAXM))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.st = 0; r.left = 0; r.sel = '0; r.level = 0; r.score = 0; r.misses = 0;
    return r;
  endfunction

  // One clock of game rules; 'left' counts the cycles still to spend in a timed phase.
  function automatic mdl_t mdl_step(mdl_t m, bit start, bit [11:0] tog, bit submit, int n_chords);
    mdl_t n = m;
    case (m.st)
      0, 6, 7: if (start) begin
        n = mdl_reset();
        n.st = 1; n.left = SHOW;
      end
      1: if (m.left == 1) begin n.st = 2; n.sel = '0; end
         else n.left = m.left - 1;
      2: begin
        n.sel = m.sel ^ tog;
        if (submit) n.st = 3;
      end
      3: begin
        n.left = FB;
        if (m.sel == CHORDS[m.level]) begin
          n.st = 4; n.score = (m.score < 15) ? m.score + 1 : 15;
        end else begin
          n.st = 5; n.misses = (m.misses < MAXM) ? m.misses + 1 : MAXM;
        end
      end
      4: if (m.left == 1) begin
        if (m.level == n_chords - 1) n.st = 7;
        else begin n.st = 1; n.level = m.level + 1; n.left = SHOW; end
      end else n.left = m.left - 1;
      5: if (m.left == 1) begin
        if (m.misses == MAXM) n.st = 6;
        else begin n.st = 1; n.left = SHOW; end
      end else n.left = m.left - 1;
      default: n = mdl_reset();
    endcase
    return n;
  endfunction

  function automatic bit [11:0] mdl_ks(mdl_t m);
    case (m.st)
      1, 4:    return CHORDS[m.level];
      2, 3:    return m.sel;
      5:       return m.sel ^ CHORDS[m.level];
      7:       return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string who, input mdl_t m, input logic [2:0] st,
                         input logic [11:0] ks, input logic [2:0] lv, input logic [3:0] sc,
                         input logic [1:0] mi, input logic go, input logic wn);
    check({who, ".state"},      32'(st), 32'(m.st));
    check({who, ".key_select"}, 32'(ks), 32'(mdl_ks(m)));
    check({who, ".level"},      32'(lv), 32'(m.level));
    check({who, ".score"},      32'(sc), 32'(m.score));
    check({who, ".misses"},     32'(mi), 32'(m.misses));
    check({who, ".game_over"},  32'(go), 32'(m.st == 6));
    check({who, ".win"},        32'(wn), 32'(m.st == 7));
  endtask

  task automatic compare_all();
    cmp_dut("d8", m8, if8.state_o, if8.key_select, if8.level, if8.score, if8.misses,
            if8.game_over, if8.win);
    cmp_dut("d2", m2, if2.state_o, if2.key_select, if2.level, if2.score, if2.misses,
            if2.game_over, if2.win);
  endtask

  task automatic drive(input bit s, input bit [11:0] t, input bit sub);
    if8.start = s; if8.key_toggle = t; if8.submit = sub;
    if2.start = s; if2.key_toggle = t; if2.submit = sub;
`ifdef CHORD_HINT_EN
    if8.hint = 1'b0; if2.hint = 1'b0;
`endif
  endtask

  // Drive inputs, take one edge, advance the model, then compare 1 ns after the edge.
  task automatic cycle(input bit s, input bit [11:0] t, input bit sub);
    drive(s, t, sub);
    @(posedge clk);
    m8 = mdl_step(m8, s, t, sub, 8);
    m2 = mdl_step(m2, s, t, sub, 2);
    #1;
    compare_all();
  endtask

  task automatic wait_play();
    for (int i = 0; i < 40 && m8.st != 2; i++) cycle(1'b0, 12'h000, 1'b0);
    check("reach_play", 32'(if8.state_o), 32'd2);
  endtask

  // Called 1 ns after an edge; reset must act without waiting for a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m8 = mdl_reset();
    m2 = mdl_reset();
    compare_all();
    check("rst.state",      32'(if8.state_o),    32'd0);
    check("rst.key_select", 32'(if8.key_select), 32'h000);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    bit        s;
    bit        sub;
    bit [11:0] t;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 12'h000, 1'b0);
    m8 = mdl_reset();
    m2 = mdl_reset();
    #12;
    compare_all();
    check("reset.level", 32'(if8.level), 32'd0);
    #8;
    rst_n = 1'b1;

    // First chord shown for exactly SHOW cycles, then an empty selection.
    cycle(1'b1, 12'h000, 1'b0);
    check("show.target", 32'(if8.key_select), 32'h091);
    for (int i = 0; i < SHOW - 1; i++) cycle(1'b0, 12'h000, 1'b0);
    check("show.still", 32'(if8.state_o), 32'd1);
    cycle(1'b0, 12'h000, 1'b0);
    check("play.entry", 32'(if8.state_o), 32'd2);
    check("play.empty", 32'(if8.key_select), 32'h000);

    // Build C major; last toggle coincides with submit.
    cycle(1'b0, 12'h001, 1'b0);
    cycle(1'b0, 12'h010, 1'b0);
    check("play.partial", 32'(if8.key_select), 32'h011);
    cycle(1'b0, 12'h080, 1'b1);
    check("check.sel", 32'(if8.key_select), 32'h091);
    cycle(1'b0, 12'h000, 1'b0);
    check("correct.ks", 32'(if8.key_select), 32'h091);
    check("correct.score", 32'(if8.score), 32'd1);
    cycle(1'b0, 12'h000, 1'b0);
    cycle(1'b0, 12'h000, 1'b0);
    check("lvl1.level", 32'(if8.level), 32'd1);
    check("lvl1.show", 32'(if8.key_select), 32'h221);

    // Three wrong submissions end the game.
    for (int k = 0; k < MAXM; k++) begin
      wait_play();
      cycle(1'b0, 12'h000, 1'b1);
    end
    for (int i = 0; i < 1 + FB; i++) cycle(1'b0, 12'h000, 1'b0);
    check("go.flag", 32'(if8.game_over), 32'd1);
    check("go.ks", 32'(if8.key_select), 32'h000);
    check("go.misses", 32'(if8.misses), 32'd3);

    cycle(1'b1, 12'h000, 1'b0);
    check("restart.state", 32'(if8.state_o), 32'd1);
    check("restart.score", 32'(if8.score), 32'd0);
    check("restart.misses", 32'(if8.misses), 32'd0);

    // Wrong at level 0: feedback shows wrong plus missing keys, level unchanged.
    wait_play();
    cycle(1'b0, 12'h011, 1'b1);
    cycle(1'b0, 12'h000, 1'b0);
    check("wrong.ks", 32'(if8.key_select), 32'h080);
    check("wrong.misses", 32'(if8.misses), 32'd1);
    cycle(1'b0, 12'h000, 1'b0);
    cycle(1'b0, 12'h000, 1'b0);
    check("wrong.reshow", 32'(if8.state_o), 32'd1);
    check("wrong.level", 32'(if8.level), 32'd0);

    // Two correct chords: the 2-chord game wins.
    wait_play();
    cycle(1'b0, 12'h091, 1'b1);
    wait_play();
    cycle(1'b0, 12'h221, 1'b1);
    for (int i = 0; i < 1 + FB; i++) cycle(1'b0, 12'h000, 1'b0);
    check("win.flag", 32'(if2.win), 32'd1);
    check("win.ks", 32'(if2.key_select), 32'hFFF);
    check("win.score", 32'(if2.score), 32'd2);
    check("d8.lvl2", 32'(if8.key_select), 32'h884);

    // Reset in the middle of PLAY.
    wait_play();
    cycle(1'b0, 12'h091, 1'b0);
    check("midplay.sel", 32'(if8.key_select), 32'h091);
    do_reset();
    check("midrst.level", 32'(if8.level), 32'd0);
    check("midrst.score", 32'(if2.score), 32'd0);

    // Randomized play, biased towards correct answers so games progress.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(599) == 0) begin
        do_reset();
        continue;
      end
      s   = (m8.st == 0 || m8.st >= 6) ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
      t   = ($urandom_range(2) == 0) ? 12'($urandom) : 12'h000;
      sub = ($urandom_range(15) == 0);
      if (m8.st == 2) begin
        if ($urandom_range(1) == 0) t = m8.sel ^ CHORDS[m8.level];
        sub = ($urandom_range(3) == 0);
      end
      cycle(s, t, sub);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chord_game_ctrl.md
Name: chord_game_ctrl

Overview:
- Game sequencer for the piano display: owns the 12-bit key highlight vector (bit 0 = C ... bit 11 = B; C2 is never driven) consumed by the VGA piano renderer.
- Presents a target chord from an internal 8-entry table, collects the player's debounced key toggles, checks the submission, tracks score and misses, and advances through levels.
- Sits between button/switch debouncers and the renderer; one instance per design.

Parameters:
- SHOW_CYCLES, 50000000, cycles the target chord is displayed in SHOW (1 s at 50 MHz); 27-bit counter.
- FB_CYCLES, 25000000, cycles for CORRECT/WRONG feedback display.
- NUM_CHORDS, 8, chords per game, 1..8.
- MAX_MISSES, 3, wrong submissions that end the game, 1..3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a game from IDLE, GAME_OVER or WIN
- key_toggle  in  12  single-cycle pulses; bit i toggles player selection bit i
- submit  in  1  single-cycle pulse; player commits selection
- key_select  out  12  registered highlight vector to the renderer
- level  out  3  current chord index (displayed as level+1)
- score  out  4  correct chords this game
- misses  out  2  wrong submissions this game
- state_o  out  3  FSM state encoding
- game_over  out  1  high in GAME_OVER
- win  out  1  high in WIN

Behaviour:
- Reset (async, rst_n low): state IDLE, key_select=0, level=0, score=0, misses=0, player selection=0, timer=0, game_over=0, win=0.
- Chord table (combinational, index = level): 0 C maj 0x091, 1 F maj 0x221, 2 G maj 0x884, 3 D min 0x224, 4 A min 0x211, 5 E min 0x890, 6 D maj 0x244, 7 E maj 0x910.
- States/encoding: IDLE=0, SHOW=1, PLAY=2, CHECK=3, CORRECT=4, WRONG=5, GAME_OVER=6, WIN=7.
- IDLE: key_select=0. On start: clear level/score/misses/selection, go to SHOW, timer=0.
- SHOW: key_select=target; timer increments each cycle; when timer==SHOW_CYCLES-1 go to PLAY, clear timer and selection. Inputs ignored.
- PLAY: key_select=selection (updated the cycle after a toggle pulse; multiple bits in one pulse all toggle). On submit go to CHECK. If submit and key_toggle coincide, the toggle is applied first and the updated selection is checked.
- CHECK: one cycle. selection==target (exact 12-bit equality) -> CORRECT, score+1; else -> WRONG, misses+1. key_select holds selection.
- CORRECT: key_select=target for FB_CYCLES. Then: if level==NUM_CHORDS-1 -> WIN; else level+1 and go to SHOW.
- WRONG: key_select=selection XOR target (highlights wrong plus missing keys) for FB_CYCLES. Then: if misses==MAX_MISSES -> GAME_OVER; else go to SHOW, same level.
- GAME_OVER / WIN: key_select=0x000 / 0xFFF respectively; counters hold; on start restart as from IDLE.
- start outside IDLE/GAME_OVER/WIN is ignored; submit outside PLAY is ignored.
- Counters never wrap: score saturates at 15, misses bounded by MAX_MISSES, level bounded by NUM_CHORDS-1.
- All outputs are registered; key_select changes on the cycle the state transition registers.
- Reset asserted mid-game returns to the reset state immediately, regardless of state or timer value.

Optional Feature:
- CHORD_HINT_EN. When defined, an extra input hint (1 bit, single-cycle pulse) is present. A hint pulse in PLAY saves the selection and enters SHOW for SHOW_CYCLES. It then returns to PLAY with the saved selection restored (not cleared). Each hint sets an internal hint_used flag for the current chord; a CORRECT with hint_used set does not increment score. hint_used clears on level advance.
- When not defined, the hint port does not exist and SHOW always clears the selection on exit.

Test Plan:
- SHOW_CYCLES=4, FB_CYCLES=2: reset, start -> SHOW with key_select=0x091 for exactly 4 cycles, then PLAY with key_select=0x000.
- In PLAY, toggle bits 0, 4, 7 (any order/cycles), then submit -> CHECK, CORRECT with key_select=0x091, score=1, level=1, SHOW shows 0x221.
- Level 0, select 0x011, submit -> WRONG with key_select=0x080, misses=1, return to SHOW with level=0.
- MAX_MISSES=3: three wrong submits -> GAME_OVER, game_over=1, key_select=0; start -> SHOW at level 0 with score=misses=0.
- NUM_CHORDS=2: two correct chords -> WIN, win=1, key_select=0xFFF, score=2.
- Assert rst_n low mid-PLAY with selection 0x091 -> next observation IDLE, key_select=0, level=score=misses=0; same-cycle toggle+submit is checked using the post-toggle selection.
